mux_sel_arb: RTL and testbench

MUX_SEL_ARB -- requirements
Module: mux_sel_arb

---
 rtl/mux_sel_arb_pkg.sv | 12 +
 rtl/mux_sel_arb_rr_pick.sv | 26 ++
 rtl/mux_sel_arb.sv | 102 ++++++++++
 tb/tb_mux_sel_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_arb_pkg.sv
// Shared types and constants for the four-channel round-robin mux-select arbiter.
package mux_sel_arb_pkg;

    localparam int N_CH  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_sel_arb_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, modulo N_CH.
module rr_pick
    import mux_sel_arb_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = ptr;
        cand = ptr;
        any  = |req;
        // Walk offsets downward so the closest requester to ptr is written last and wins.
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter driving the select lines of a 4:1 mux, with a per-turn hold limit.
// state | meaning
// IDLE  | no owner; arbitrate on any request, s1/s2 keep the last owner index
// GRANT | owner holds mux select; release on done, owner drop or hold limit
module mux_sel_arb
    import mux_sel_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            done,
    output logic [N_CH-1:0] gnt,
    output logic            s1,
    output logic            s2,
    output logic            busy
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [7:0]       hold_cnt, hold_cnt_nxt;
    logic [N_CH-1:0]  gnt_q, gnt_nxt;
    logic             busy_q, busy_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Every release cause collapses into one condition, so coincident causes act as one.
    assign rel = done | ~req[sel] | (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt_q;
        busy_nxt     = busy_q;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (pick_any) begin
                    state_nxt    = GRANT;
                    sel_nxt      = pick_idx;
                    gnt_nxt      = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = 8'd0;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = sel + IDX_W'(1);
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= 8'd0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt_q    <= gnt_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign s1   = sel[1];
    assign s2   = sel[0];

endmodule

// File: tb/tb_mux_sel_arb.sv
// Scoreboard bench for mux_sel_arb: expected grants are queued by the stimulus and
// checked by a negedge monitor, together with the 4:1 mux output they select.
module tb_mux_sel_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic       busy;
    logic [7:0] y;

    localparam logic [7:0] DAT_A = 8'hA0;
    localparam logic [7:0] DAT_B = 8'hB1;
    localparam logic [7:0] DAT_C = 8'hC2;
    localparam logic [7:0] DAT_D = 8'hD3;

    typedef struct {
        logic [3:0] gnt;
        int         len;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   grants_started = 0;
    int   grants_done    = 0;

    mux_sel_arb #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .s1    (s1),
        .s2    (s2),
        .busy  (busy)
    );

    assign y = s1 ? (s2 ? DAT_D : DAT_C) : (s2 ? DAT_B : DAT_A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] dat_of(input int i);
        case (i)
            0:       return DAT_A;
            1:       return DAT_B;
            2:       return DAT_C;
            default: return DAT_D;
        endcase
    endfunction

    function automatic exp_t mk(input logic [3:0] g, input int len, input int gap);
        exp_t e;
        e.gnt = g;
        e.len = len;
        e.gap = gap;
        return e;
    endfunction

    // Monitor: tracks grant windows, checks owner, select, mux data, length and gap.
    exp_t cur;
    bit   in_grant = 0;
    int   len_cnt  = 0;
    int   idle_cnt = 0;
    int   sel_hold = 0;

    always @(negedge clk) begin
        if (in_grant) begin
            if (gnt == cur.gnt) begin
                len_cnt++;
                chk("busy_in_grant", int'(busy), 1);
                chk("sel_in_grant", int'({s1, s2}), idx_of(cur.gnt));
                chk("mux_y", int'(y), int'(dat_of(idx_of(cur.gnt))));
            end else begin
                chk("grant_len", len_cnt, cur.len);
                if (gnt != 4'b0) chk("gnt_switch_no_idle", int'(gnt), 0);
                grants_done++;
                in_grant = 0;
                idle_cnt = 0;
            end
        end
        if (!in_grant) begin
            if (gnt != 4'b0 && rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(gnt), 0);
                    cur = mk(gnt, -1, -1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_owner", int'(gnt), int'(cur.gnt));
                    if (cur.gap >= 0) chk("idle_gap", idle_cnt, cur.gap);
                end
                in_grant = 1;
                len_cnt  = 1;
                sel_hold = idx_of(cur.gnt);
                grants_started++;
                chk("busy_start", int'(busy), 1);
                chk("sel_start", int'({s1, s2}), sel_hold);
                chk("mux_y_start", int'(y), int'(dat_of(sel_hold)));
            end else begin
                if (!rst_n) sel_hold = 0;
                chk("busy_idle", int'(busy), 0);
                chk("sel_hold_idle", int'({s1, s2}), sel_hold);
                idle_cnt++;
            end
        end
    end

    task automatic wait_started(input int target, input int budget);
        int n = 0;
        while (grants_started < target) begin
            @(negedge clk);
            #1;
            n++;
            if (n > budget) begin
                total++;
                bad++;
                $display("FAIL wait_start timeout actual=%0d required=%0d", grants_started, target);
                return;
            end
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (grants_done < target) begin
            @(negedge clk);
            #1;
            n++;
            if (n > budget) begin
                total++;
                bad++;
                $display("FAIL wait_done timeout actual=%0d required=%0d", grants_done, target);
                return;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_sel"}, int'({s1, s2}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0001;
        done  = 1'b0;

        // Reset with ch0 requesting; first edge after release grants ch0.
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        exp_q.push_back(mk(4'b0001, 8, -1));
        rst_n = 1'b1;
        wait_done(1, 40);
        req = 4'b0000;
        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        done = 1'b0;

        // Reset clears ptr, then full rotation with all four requesting.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst2");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(4'b0001, 8, -1));
        exp_q.push_back(mk(4'b0010, 8, 1));
        exp_q.push_back(mk(4'b0100, 8, 1));
        exp_q.push_back(mk(4'b1000, 8, 1));
        exp_q.push_back(mk(4'b0001, 8, 1));
        req = 4'b1111;
        wait_done(grants_done + 5, 80);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;

        // ptr=1: ch2 owns, other requests change, done in cycle 3; ptr=3 wraps to ch0.
        exp_q.push_back(mk(4'b0100, 3, -1));
        exp_q.push_back(mk(4'b0001, 1, 1));
        req = 4'b0100;
        wait_started(grants_started + 1, 10);
        req = 4'b0101;
        repeat (2) @(negedge clk);
        #1;
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        wait_started(grants_started + 1, 10);
        req = 4'b0000;
        wait_done(grants_done + 1, 10);
        repeat (2) @(negedge clk);
        #1;

        // ptr=1: ch1 owns; done, req[1] drop and hold limit coincide; next search from ptr=2.
        exp_q.push_back(mk(4'b0010, 8, -1));
        exp_q.push_back(mk(4'b0100, 1, 1));
        req = 4'b0010;
        wait_started(grants_started + 1, 10);
        repeat (7) @(negedge clk);
        #1;
        done = 1'b1;
        req  = 4'b0111;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b0;
        req  = 4'b0111;
        wait_started(grants_started + 1, 10);
        req = 4'b0000;
        wait_done(grants_done + 1, 10);
        repeat (2) @(negedge clk);
        #1;

        // ptr=3: ch3 owns, reset mid-grant; after release ch3 found from ptr=0.
        exp_q.push_back(mk(4'b1000, 3, -1));
        exp_q.push_back(mk(4'b1000, 1, -1));
        req = 4'b1000;
        wait_started(grants_started + 1, 10);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_started(grants_started + 1, 10);
        req = 4'b0000;
        wait_done(grants_done + 1, 10);
        repeat (3) @(negedge clk);
        #1;

        chk("exp_q_empty", exp_q.size(), 0);
        chk("grant_closed", int'(in_grant), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
